bin2bcd_seq_arbiter: RTL and testbench

- Shared, time-multiplexed binary-to-BCD conversion resource.
- Arbitrates round-robin between NUM_REQ requesters and runs one double-dabble step per clock on a single shared shift register.
- Returns four BCD digits tagged with the requester index.
- Sits between display/UART formatters and replaces per-client combinational converters.

---
 rtl/bin2bcd_seq_arbiter.sv | 98 +++++++++
 tb/tb_bin2bcd_seq_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq_arbiter.sv
// bin2bcd_seq_arbiter: round-robin shared double-dabble binary-to-BCD converter, one step per clock.
// Optional BIN2BCD_OVERFLOW_FLAG_EN adds ovf, flagging captured operands above 9999.
module bin2bcd_seq_arbiter #(
  parameter int SIZE    = 8,
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*SIZE-1:0] a_in,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              done_id,
  output logic [3:0]              ones,
  output logic [3:0]              tens,
  output logic [3:0]              hundreds,
  output logic [3:0]              thousands
`ifdef BIN2BCD_OVERFLOW_FLAG_EN
  ,
  output logic                    ovf
`endif
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [SIZE+15:0] sr, adj;
  logic [SIZE-1:0] op;
  logic [3:0] cnt;
  logic [1:0] rr, win, owner;
  logic any;
  always_comb begin
    win = '0;
    any = 1'b0;
    // scan downward so the nearest set bit at or above rr wins
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rr) + i) % NUM_REQ]) begin
        win = 2'((int'(rr) + i) % NUM_REQ);
        any = 1'b1;
      end
    end
    op = a_in[int'(win)*SIZE +: SIZE];
  end
  always_comb begin
    adj = sr;
    for (int k = 0; k < 4; k++)
      adj[SIZE+4*k +: 4] = sr[SIZE+4*k +: 4] >= 4'd5 ? sr[SIZE+4*k +: 4] + 4'd3 : sr[SIZE+4*k +: 4];
  end
  always_comb begin
    state_n = state == IDLE  ? (any ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == 4'd1 ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
`ifdef BIN2BCD_OVERFLOW_FLAG_EN
  logic big;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      big <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && any) begin
      big <= 32'(op) > 32'd9999;
    end else if (state == SHIFT && cnt == 4'd1) begin
      ovf <= big;
    end
  end
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
      cnt <= '0;
      rr <= '0;
      owner <= '0;
      gnt <= '0;
      done_id <= '0;
      {thousands, hundreds, tens, ones} <= '0;
    end else begin
      gnt <= '0;
      if (state == IDLE && any) begin
        sr <= {16'b0, op};
        cnt <= 4'(SIZE);
        gnt <= NUM_REQ'(1 << win);
        owner <= win;
        rr <= 2'((int'(win) + 1) % NUM_REQ);
      end else if (state == SHIFT) begin
        sr <= {adj[SIZE+14:0], 1'b0};
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          {thousands, hundreds, tens, ones} <= adj[SIZE+14:SIZE-1];
          done_id <= owner;
        end
      end
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq_arbiter.sv
// tb_bin2bcd_seq_arbiter: directed vectors with hand-computed BCD results, latencies and grant order.
module tb_bin2bcd_seq_arbiter;
`ifdef BIN2BCD_OVERFLOW_FLAG_EN
  localparam int SIZE = 14;
`else
  localparam int SIZE = 8;
`endif
  localparam int NR = 2;
  logic clk = 0, reset = 1;
  logic [NR-1:0] req = '0;
  logic [NR*SIZE-1:0] a_in = '0;
  logic [NR-1:0] gnt;
  logic busy, done;
  logic [1:0] done_id;
  logic [3:0] ones, tens, hundreds, thousands;
  logic [15:0] dig;
  int vec = 0, errs = 0;
  int n, nb, ng, nd;
  logic [NR-1:0] g;
`ifdef BIN2BCD_OVERFLOW_FLAG_EN
  logic ovf;
`endif
  bin2bcd_seq_arbiter #(.SIZE(SIZE), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .gnt(gnt), .busy(busy), .done(done),
    .done_id(done_id), .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands)
`ifdef BIN2BCD_OVERFLOW_FLAG_EN
    , .ovf(ovf)
`endif
  );
  assign dig = {thousands, hundreds, tens, ones};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_op(input int k, input int v);
    a_in[k*SIZE +: SIZE] = SIZE'(v);
  endtask
  // runs from a negedge until done is seen; n counts negedges, so capture edge ends cycle 0
  task automatic wait_done(input bit hold);
    n = 0; nb = 0; ng = 0; g = '0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (gnt != 0) begin
        ng++;
        g = gnt;
        if (!hold) req = req & ~gnt;
      end
    end while (!done && n < 100);
    if (!done) check("done_timeout", 0, 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_id", done_id, 0);
    check("rst_dig", dig, 0);
    reset = 0;
    @(negedge clk);
    set_op(0, 255); req = 2'b01;
    wait_done(0);
    check("t1_lat", n, SIZE + 1);
    check("t1_gnt", g, 2'b01);
    check("t1_gnt_width", ng, 1);
    check("t1_busy_cycles", nb, SIZE + 1);
    check("t1_dig", dig, 16'h0255);
    check("t1_id", done_id, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_busy_low", busy, 0);
    check("t1_dig_hold", dig, 16'h0255);
    reset = 1; @(negedge clk); reset = 0; @(negedge clk);
    set_op(0, 42); set_op(1, 7); req = 2'b11;
    wait_done(0);
    check("t2a_gnt", g, 2'b01);
    check("t2a_dig", dig, 16'h0042);
    check("t2a_id", done_id, 0);
    wait_done(0);
    check("t2_done_spacing", n, SIZE + 2);
    check("t2b_gnt", g, 2'b10);
    check("t2b_dig", dig, 16'h0007);
    check("t2b_id", done_id, 1);
    req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      wait_done(1);
      check("t3_gnt", g, i % 2 == 0 ? 2'b01 : 2'b10);
      check("t3_id", done_id, i % 2);
      check("t3_dig", dig, i % 2 == 0 ? 16'h0042 : 16'h0007);
    end
    req = '0;
    @(negedge clk);
    set_op(0, 0); req = 2'b01;
    wait_done(0);
    check("t4_zero_done", done, 1);
    check("t4_zero_dig", dig, 0);
    set_op(0, 99); req = 2'b01;
    wait_done(0);
    check("t4_99_dig", dig, 16'h0099);
    @(negedge clk);
    set_op(0, 200); req = 2'b01;
    repeat (4) @(negedge clk);
    req = '0;
    reset = 1;
    #1;
    check("t5_gnt", gnt, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_dig", dig, 0);
    check("t5_id", done_id, 0);
    @(negedge clk); reset = 0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("t5_no_done", nd, 0);
    set_op(0, 128); set_op(1, 5); req = 2'b11;
    wait_done(0);
    check("t5_rr_cleared", g, 2'b01);
    check("t5_dig", dig, 16'h0128);
    check("t5_id", done_id, 0);
    wait_done(0);
    check("t5b_dig", dig, 16'h0005);
`ifdef BIN2BCD_OVERFLOW_FLAG_EN
    set_op(0, 9999); req = 2'b01;
    wait_done(0);
    check("t6_9999_dig", dig, 16'h9999);
    check("t6_9999_ovf", ovf, 0);
    set_op(0, 10000); req = 2'b01;
    wait_done(0);
    check("t6_10000_dig", dig, 16'h0000);
    check("t6_10000_ovf", ovf, 1);
    set_op(0, 16383); req = 2'b01;
    wait_done(0);
    check("t6_16383_dig", dig, 16'h6383);
    check("t6_16383_ovf", ovf, 1);
    set_op(0, 0); req = 2'b01;
    wait_done(0);
    check("t6_0_ovf", ovf, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
